// File: rtl/proj_mux_ctrl.sv
// Project-select controller: tracks the selected project address,
// drives a break-before-make one-hot enable and registers its outputs.
module proj_mux_ctrl #(
    parameter int NUM_PROJ = 32,
    parameter int ADDR_W   = 5,
    parameter int SETTLE   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sel_rst_n,
    input  logic                   sel_inc,
    input  logic                   ctrl_ena,
    input  logic                   proj_clk,
    input  logic                   proj_rst_n,
    input  logic [7:0]             ui_in,
    input  logic [7:0]             uio_in,
    output logic [17:0]            iw,
    output logic [NUM_PROJ-1:0]    ena,
    input  logic [24*NUM_PROJ-1:0] ow_all,
    output logic [7:0]             uo_out,
    output logic [7:0]             uio_out,
    output logic [7:0]             uio_oe,
    output logic [ADDR_W-1:0]      addr
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PROJ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETL,
        ACTIVE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [1:0]        rst_sync;
    logic [1:0]        inc_sync;
    logic [1:0]        ena_sync;
    logic              s_inc_q;
    logic              s_rst;
    logic              s_inc;
    logic              s_ena;
    logic              inc_pulse;
    logic [ADDR_W-1:0] addr_nxt;
    logic              addr_chg;
    logic [23:0]       sel_ow;

    assign iw = {uio_in, ui_in, proj_rst_n, proj_clk};

    assign s_rst     = rst_sync[1];
    assign s_inc     = inc_sync[1];
    assign s_ena     = ena_sync[1];
    assign inc_pulse = s_inc & ~s_inc_q;

    // Two-flop synchronisers for the slow pad strobes plus inc edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
            inc_sync <= '0;
            ena_sync <= '0;
            s_inc_q  <= 1'b0;
        end else begin
            rst_sync <= {rst_sync[0], sel_rst_n};
            inc_sync <= {inc_sync[0], sel_inc};
            ena_sync <= {ena_sync[0], ctrl_ena};
            s_inc_q  <= s_inc;
        end
    end

    // Next address: pad reset wins over an increment, wrap at NUM_PROJ-1
    always_comb begin
        addr_nxt = addr;
        if (!s_rst) begin
            addr_nxt = '0;
        end else if (inc_pulse) begin
            addr_nxt = (addr == LAST) ? '0 : addr + 1'b1;
        end
    end

    assign addr_chg = (addr_nxt != addr);

    // Address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else begin
            addr <= addr_nxt;
        end
    end

    // Pick the selected wrapper's output slice
    always_comb begin
        sel_ow = '0;
        for (int p = 0; p < NUM_PROJ; p++) begin
            if (addr == ADDR_W'(p)) begin
                sel_ow = ow_all[24*p +: 24];
            end
        end
    end

    // Select FSM with registered enable and pad outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ena     <= '0;
            uo_out  <= '0;
            uio_out <= '0;
            uio_oe  <= '0;
        end else begin
            ena     <= '0;
            uo_out  <= '0;
            uio_out <= '0;
            uio_oe  <= '0;
            unique case (state)
                IDLE: begin
                    if (s_ena) begin
                        state <= SETL;
                        cnt   <= CW'(SETTLE - 1);
                    end
                end
                SETL: begin
                    if (!s_ena) begin
                        state <= IDLE;
                    end else if (addr_chg) begin
                        cnt <= CW'(SETTLE - 1);
                    end else if (cnt == '0) begin
                        state <= ACTIVE;
                        ena   <= NUM_PROJ'(1) << addr;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!s_ena) begin
                        state <= IDLE;
                    end else if (addr_chg) begin
                        state <= SETL;
                        cnt   <= CW'(SETTLE - 1);
                    end else begin
                        ena     <= ena;
                        uo_out  <= sel_ow[7:0];
                        uio_out <= sel_ow[15:8];
                        uio_oe  <= sel_ow[23:16];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proj_mux_ctrl.sv
// Randomised bench for proj_mux_ctrl against a behavioural model
// of the select/settle/capture rules.
module tb_proj_mux_ctrl;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int S  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sel_rst_n;
    logic            sel_inc;
    logic            ctrl_ena;
    logic            proj_clk;
    logic            proj_rst_n;
    logic [7:0]      ui_in;
    logic [7:0]      uio_in;
    logic [17:0]     iw;
    logic [N-1:0]    ena;
    logic [24*N-1:0] ow_all;
    logic [7:0]      uo_out;
    logic [7:0]      uio_out;
    logic [7:0]      uio_oe;
    logic [AW-1:0]   addr;

    proj_mux_ctrl #(.NUM_PROJ(N), .ADDR_W(AW), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .sel_rst_n(sel_rst_n),
        .sel_inc(sel_inc), .ctrl_ena(ctrl_ena), .proj_clk(proj_clk),
        .proj_rst_n(proj_rst_n), .ui_in(ui_in), .uio_in(uio_in),
        .iw(iw), .ena(ena), .ow_all(ow_all), .uo_out(uo_out),
        .uio_out(uio_out), .uio_oe(uio_oe), .addr(addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pad history, address, phase (0 off, 1 wait, 2 on)
    bit          h_inc[3];
    bit          h_rst[3];
    bit          h_en[3];
    int          m_addr;
    int          m_phase;
    int          m_wait;
    logic [31:0] m_ena;
    logic [23:0] m_out;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            h_inc[i] = 0;
            h_rst[i] = 0;
            h_en[i]  = 0;
        end
        m_addr  = 0;
        m_phase = 0;
        m_wait  = 0;
        m_ena   = '0;
        m_out   = '0;
    endfunction

    function automatic void model_step();
        bit pulse;
        bit chg;
        int na;
        int np;
        pulse = h_inc[1] && !h_inc[2];
        if (!h_rst[1]) na = 0;
        else if (pulse) na = (m_addr + 1) % N;
        else na = m_addr;
        chg = (na != m_addr);
        np = m_phase;
        if (!h_en[1]) begin
            np = 0;
        end else if (m_phase == 0) begin
            np = 1;
            m_wait = 0;
        end else if (chg) begin
            np = 1;
            m_wait = 0;
        end else if (m_phase == 1) begin
            m_wait++;
            if (m_wait == S) np = 2;
        end
        m_out = (m_phase == 2 && np == 2) ? ow_all[24*m_addr +: 24] : 24'h0;
        m_ena = (np == 2) ? (32'h1 << na) : 32'h0;
        m_addr  = na;
        m_phase = np;
        h_inc[2] = h_inc[1]; h_inc[1] = h_inc[0]; h_inc[0] = sel_inc;
        h_rst[2] = h_rst[1]; h_rst[1] = h_rst[0]; h_rst[0] = sel_rst_n;
        h_en[2]  = h_en[1];  h_en[1]  = h_en[0];  h_en[0]  = ctrl_ena;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check("addr", 64'(addr), 64'(m_addr));
        check("ena", 64'(ena), 64'(m_ena));
        check("uo_out", 64'(uo_out), 64'(m_out[7:0]));
        check("uio_out", 64'(uio_out), 64'(m_out[15:8]));
        check("uio_oe", 64'(uio_oe), 64'(m_out[23:16]));
    endtask

    task automatic rand_data();
        for (int i = 0; i < 24; i++) ow_all[32*i +: 32] = $urandom;
        ui_in      = 8'($urandom);
        uio_in     = 8'($urandom);
        proj_clk   = 1'($urandom);
        proj_rst_n = 1'($urandom);
        #1;
        check("iw", 64'(iw), 64'({uio_in, ui_in, proj_rst_n, proj_clk}));
    endtask

    task automatic pulse_inc(input int hi, input int lo);
        sel_inc = 1'b1;
        repeat (hi) tick();
        sel_inc = 1'b0;
        repeat (lo) tick();
    endtask

    int inc_left;
    int en_left;
    int rst_left;

    initial begin
        rst_n = 1'b0; sel_rst_n = 1'b1; sel_inc = 1'b0; ctrl_ena = 1'b0;
        ow_all = '0; ui_in = '0; uio_in = '0;
        proj_clk = 1'b0; proj_rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_ena", 64'(ena), 64'h0);
        check("rst_addr", 64'(addr), 64'h0);
        check("rst_oe", 64'(uio_oe), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Select address 0 and capture a known slice
        ctrl_ena = 1'b1;
        ow_all[23:0] = 24'hA53C81;
        repeat (8) tick();
        check("sel_ena", 64'(ena), 64'h1);
        check("sel_oe", 64'(uio_oe), 64'hA5);
        check("sel_uio", 64'(uio_out), 64'h3C);
        check("sel_uo", 64'(uo_out), 64'h81);

        // Walk to the last address, then wrap
        for (int i = 0; i < 31; i++) pulse_inc(4, 4);
        repeat (4) tick();
        check("wrap_addr31", 64'(addr), 64'd31);
        check("wrap_ena31", 64'(ena), 64'h8000_0000);
        pulse_inc(4, 4);
        check("wrap_addr0", 64'(addr), 64'd0);

        // Held strobe and pad reset priority
        pulse_inc(20, 4);
        check("held_addr", 64'(addr), 64'd1);
        sel_rst_n = 1'b0;
        pulse_inc(4, 4);
        pulse_inc(4, 4);
        check("rstpri_addr", 64'(addr), 64'd0);
        sel_rst_n = 1'b1;
        repeat (3) tick();
        pulse_inc(4, 4);
        check("rstpri_next", 64'(addr), 64'd1);

        // Randomised operation
        inc_left = 1; en_left = 50; rst_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (--inc_left <= 0) begin
                sel_inc = ~sel_inc;
                inc_left = ($urandom_range(0, 15) == 0) ?
                           $urandom_range(15, 25) : $urandom_range(1, 8);
            end
            if (--en_left <= 0) begin
                ctrl_ena = ($urandom_range(0, 9) < 8);
                en_left = $urandom_range(5, 150);
            end
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) sel_rst_n = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                sel_rst_n = 1'b0;
                rst_left = $urandom_range(2, 12);
            end
            rand_data();
            if (c == 2000) begin
                rst_n = 1'b0;
                #1;
                check("mid_rst_ena", 64'(ena), 64'h0);
                check("mid_rst_addr", 64'(addr), 64'h0);
                check("mid_rst_uo", 64'(uo_out), 64'h0);
                check("mid_rst_oe", 64'(uio_oe), 64'h0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
